// File: rtl/montpro_pkg.sv
// Shared types and helpers for the montpro_dsm digit-serial Montgomery multiplier.
package montpro_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SUB  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int WID_DEF   = 256;
    localparam int DIG_DEF   = 2;
    localparam int ACC_W_DEF = WID_DEF + DIG_DEF + 2;

    localparam logic [ACC_W_DEF-1:0] ACC_ZERO = '0;

    function automatic int ndig(input int wid, input int dig);
        return wid / dig;
    endfunction

endpackage

// File: rtl/montpro_dsm_pe.sv
// One radix-2^DIG Montgomery digit step: acc' = (acc + a_i*b + q*m) >> DIG.
module montpro_dsm_pe #(
    parameter int WID = 256,
    parameter int DIG = 2,
    localparam int ACC_W = WID + DIG + 2
) (
    input  logic [WID:0]   acc,
    input  logic [DIG-1:0] a_i,
    input  logic [WID-1:0] b,
    input  logic [WID-1:0] m,
    input  logic [DIG-1:0] minv,
    output logic [WID:0]   acc_nxt
);

    logic [ACC_W-1:0] t;
    logic [ACC_W-1:0] u;
    logic [DIG-1:0]   q;

    always_comb begin
        t = ACC_W'(acc) + ACC_W'(a_i) * ACC_W'(b);
        // q makes the low DIG bits of t + q*m vanish, so the shift below is exact.
        q = DIG'(t[DIG-1:0] * minv);
        u = t + ACC_W'(q) * ACC_W'(m);
        acc_nxt = (WID+1)'(u >> DIG);
    end

endmodule

// File: rtl/montpro_dsm.sv
// Digit-serial Montgomery multiplier with start/busy/done handshake.
// Define MONTPRO_FINALSUB_EN to add the final conditional subtraction (r < m).
module montpro_dsm
    import montpro_pkg::*;
#(
    parameter int WID = 256,
    parameter int DIG = 2,
    localparam int NDIG = ndig(WID, DIG)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [WID-1:0] a,
    input  logic [WID-1:0] b,
    input  logic [WID-1:0] m,
    input  logic [DIG-1:0] minv,
    output logic           busy,
    output logic           done,
    output logic [WID:0]   r
);

    localparam int CNT_W = $clog2(NDIG + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDIG - 1);

    state_e           state_q, state_d;
    logic [WID-1:0]   asrg_q, asrg_d;
    logic [WID-1:0]   b_q, b_d;
    logic [WID-1:0]   m_q, m_d;
    logic [DIG-1:0]   minv_q, minv_d;
    logic [WID:0]     acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WID:0]     r_q, r_d;
    logic [WID:0]     acc_nxt;

    montpro_dsm_pe #(
        .WID (WID),
        .DIG (DIG)
    ) u_pe (
        .acc     (acc_q),
        .a_i     (asrg_q[DIG-1:0]),
        .b       (b_q),
        .m       (m_q),
        .minv    (minv_q),
        .acc_nxt (acc_nxt)
    );

`ifdef MONTPRO_FINALSUB_EN
    // One extra bit on top catches the borrow of acc - m.
    logic [WID+1:0] diff;
    assign diff = {1'b0, acc_q} - {2'b00, m_q};
`endif

    always_comb begin
        // NOTE: every variable gets its hold value first so no path infers a latch.
        state_d = state_q;
        asrg_d  = asrg_q;
        b_d     = b_q;
        m_d     = m_q;
        minv_d  = minv_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    asrg_d  = a;
                    b_d     = b;
                    m_d     = m;
                    minv_d  = minv;
                    acc_d   = (WID+1)'(ACC_ZERO);
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d  = acc_nxt;
                asrg_d = asrg_q >> DIG;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
`ifdef MONTPRO_FINALSUB_EN
                    state_d = SUB;
`else
                    state_d = DONE;
                    r_d     = acc_nxt;
`endif
                end
            end
`ifdef MONTPRO_FINALSUB_EN
            SUB: begin
                r_d     = diff[WID+1] ? acc_q : diff[WID:0];
                state_d = DONE;
            end
`endif
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            state_q <= IDLE;
            asrg_q  <= '0;
            b_q     <= '0;
            m_q     <= '0;
            minv_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            asrg_q  <= asrg_d;
            b_q     <= b_d;
            m_q     <= m_d;
            minv_q  <= minv_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
        end
    end

    assign busy = (state_q == RUN) || (state_q == SUB);
    assign done = (state_q == DONE);
    assign r    = r_q;

endmodule

// File: doc/montpro_dsm.md
Name: montpro_dsm

Overview:
- Parametrised digit-serial Montgomery multiplier, radix 2^DIG.
- Computes R = a·b·2^(−WID) mod m, consuming DIG bits of a per cycle.
- Adds a start/busy/done handshake and input latching.
- Optional final conditional subtraction gives a fully reduced result.
- Sits in the ECC core datapath and is driven by the field-arithmetic sequencer.

Parameters:
- WID, 256: operand width in bits. Must satisfy WID % DIG == 0.
- DIG, 2: digit width in bits (radix 2^DIG). Legal range 1..8.
- NDIG, WID/DIG: iteration count. Derived; do not override.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- start  in  1  one-cycle request; sampled only in IDLE
- a  in  WID  multiplicand; requires a < m
- b  in  WID  multiplier; requires b < m
- m  in  WID  modulus; odd, m < 2^(WID−1)
- minv  in  DIG  −m^(−1) mod 2^DIG, precomputed by the caller
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; r is valid from this cycle
- r  out  WID+1  result; held stable until the next accepted start

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE; busy=0; done=0; r=0; internal accumulator and counter cleared.
  - Applies mid-operation too: the computation is abandoned and no done pulse follows.
- IDLE:
  - start=1 latches a, b, m, minv into registers.
  - Accumulator is cleared, digit counter set to 0, next state RUN.
- RUN, one digit per cycle:
  - a_i = asrg[DIG−1:0].
  - t = acc + a_i·b.
  - q = (t[DIG−1:0]·minv) mod 2^DIG.
  - acc <= (t + q·m) >> DIG.
  - asrg shifts right by DIG.
  - Counter increments; after NDIG cycles the next state is SUB, or DONE if the macro is absent.
  - Widths: t and t+q·m are held in WID+DIG+2 bits. The low DIG bits of t+q·m are zero by construction. The invariant acc < 2m holds after every step.
- SUB (macro present only), one cycle:
  - d = acc − m over WID+1 bits.
  - No borrow: r <= d. Borrow: r <= acc.
- DONE, one cycle:
  - done=1, busy=0, next state IDLE.
  - r is loaded no later than this cycle.
- Latency: start sampled at edge k gives done high in cycle k+NDIG+2 (k+NDIG+1 without the macro).
  - Throughput is one result per NDIG+3 cycles, because start is accepted in IDLE only.
- start while busy or in DONE: ignored; latched operands are unaffected.
- Input changes after acceptance have no effect.
- r is not cleared at a new start; it updates only at SUB/DONE.

Optional Feature:
- MONTPRO_FINALSUB_EN defined:
  - SUB state is present.
  - r < m, and r[WID] is always 0.
- Undefined:
  - SUB is removed and RUN goes directly to DONE.
  - r = acc, 0 ≤ r < 2m, and r[WID] may be 1.
  - The consumer performs the reduction.

Decomposition:
- Package montpro_pkg holds:
  - state encoding constants: IDLE, RUN, SUB, DONE.
  - function ndig(WID, DIG).
  - a zero constant for the WID+DIG+2 accumulator width.
- One sub-module, montpro_dsm_pe: the combinational digit step.
  - Inputs: acc, a_i, b, m, minv.
  - Output: next acc.
  - Replicated nowhere; it isolates the arithmetic for unit test.
- Top level holds the FSM, counter, registers and the optional subtractor.

Test Plan:
- WID=8, DIG=2, m=13, minv=3, a=5, b=7, start at edge 0 -> done in cycle 6, r=1. Result 1 = 35·3 mod 13 with 2^(−8) ≡ 3 mod 13.
- Same config, a=12, b=12 -> r=3. Then a=0, b=9 -> r=0. With the macro undefined, a=12, b=12 -> done in cycle 5, r ≡ 3 mod 13 and r < 26.
- WID=8, DIG=1, m=13, minv=1, a=5, b=7 -> done in cycle 10, r=1. This confirms latency NDIG+2.
- start pulsed again at cycles 2 and 4 while busy, with different a -> ignored; single done pulse, r=1; busy held 1 throughout.
- rst=0 in RUN cycle 3 -> next cycle busy=0, done=0, r=0. Fresh start afterwards yields the correct result.
- WID=256, DIG=2, random odd m < 2^255 with a, b < m (1000 vectors) -> r matches the reference model a·b·2^(−256) mod m, and done is exactly 130 cycles after start.
